// File: rtl/branch_cmp_bht_if.sv
// Decode-stage branch unit bus: compare operands, branch qualifiers,
// prediction/outcome results and statistics.
interface branch_cmp_bht_if #(
   parameter int WIDTH     = 32,
   parameter int CNT_WIDTH = 16
);
   logic                 stall;
   logic                 is_branch;
   logic [31:0]          pc;
   logic [WIDTH-1:0]     cmp_a;
   logic [WIDTH-1:0]     cmp_b;
   logic [3:0]           cmp_op;
   logic                 b_jump;
   logic                 pred_taken;
   logic                 mispredict;
   logic [CNT_WIDTH-1:0] br_count;
   logic [CNT_WIDTH-1:0] mispred_count;

   // Decode pipeline side: drives the instruction, observes resolution
   modport master (
      output stall, is_branch, pc, cmp_a, cmp_b, cmp_op,
      input  b_jump, pred_taken, mispredict, br_count, mispred_count
   );

   // Branch unit side
   modport slave (
      input  stall, is_branch, pc, cmp_a, cmp_b, cmp_op,
      output b_jump, pred_taken, mispredict, br_count, mispred_count
   );
endinterface

// File: rtl/branch_cmp_bht.sv
// Branch resolution in decode: combinational compare, direct-mapped table of
// 2-bit saturating counters for prediction, registered mispredict flag and
// saturating resolved/mispredicted branch counters.
module branch_cmp_bht #(
   parameter int WIDTH     = 32,
   parameter int IDX_BITS  = 4,
   parameter int CNT_WIDTH = 16
) (
   input logic                clk,
   input logic                reset,
   branch_cmp_bht_if.slave    bus
);
   localparam int DEPTH = 2 ** IDX_BITS;

   logic [1:0]           r_bht [DEPTH];
   logic                 r_mispredict;
   logic [CNT_WIDTH-1:0] r_br_count;
   logic [CNT_WIDTH-1:0] r_mispred_count;

   logic                 w_b_jump;
   logic [IDX_BITS-1:0]  w_idx;
   logic [1:0]           w_ctr;
   logic                 w_pred;
   logic                 w_resolve;
   logic                 w_mis;
   logic                 w_unused_pc;

   assign w_idx       = bus.pc[IDX_BITS+1:2];
   assign w_unused_pc = ^{bus.pc[31:IDX_BITS+2], bus.pc[1:0]};
   assign w_ctr       = r_bht[w_idx];
   assign w_pred      = w_ctr[1];
   assign w_resolve   = bus.is_branch && !bus.stall;
   assign w_mis       = w_resolve && (w_pred != w_b_jump);

   // Branch outcome per compare op; zero-compares look only at cmp_a
   always_comb begin
      w_b_jump = 1'b0;
      case (bus.cmp_op)
         4'd1:    w_b_jump = (bus.cmp_a == bus.cmp_b);
         4'd2:    w_b_jump = (bus.cmp_a != bus.cmp_b);
         4'd3:    w_b_jump = bus.cmp_a[WIDTH-1] || (bus.cmp_a == '0);
         4'd4:    w_b_jump = !bus.cmp_a[WIDTH-1] && (bus.cmp_a != '0);
         4'd5:    w_b_jump = bus.cmp_a[WIDTH-1];
         4'd6:    w_b_jump = !bus.cmp_a[WIDTH-1];
         4'd7:    w_b_jump = ($signed(bus.cmp_a) <  $signed(bus.cmp_b));
         4'd8:    w_b_jump = (bus.cmp_a <  bus.cmp_b);
         4'd9:    w_b_jump = ($signed(bus.cmp_a) >= $signed(bus.cmp_b));
         4'd10:   w_b_jump = (bus.cmp_a >= bus.cmp_b);
         default: w_b_jump = 1'b0;
      endcase
   end

   // History table: reset to weakly not-taken, train only the indexed entry
   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < DEPTH; i++) r_bht[i] <= 2'b01;
      end else if (w_resolve) begin
         if (w_b_jump) begin
            if (w_ctr != 2'b11) r_bht[w_idx] <= w_ctr + 2'b01;
         end else begin
            if (w_ctr != 2'b00) r_bht[w_idx] <= w_ctr - 2'b01;
         end
      end
   end

   // Mispredict flag is a one-cycle pulse; stalled branches never raise it
   always_ff @(posedge clk) begin
      if (reset) r_mispredict <= 1'b0;
      else       r_mispredict <= w_mis;
   end

   // Statistics counters hold at all-ones instead of wrapping
   always_ff @(posedge clk) begin
      if (reset) begin
         r_br_count      <= '0;
         r_mispred_count <= '0;
      end else begin
         if (w_resolve && (r_br_count != '1))
            r_br_count <= r_br_count + 1'b1;
         if (w_mis && (r_mispred_count != '1))
            r_mispred_count <= r_mispred_count + 1'b1;
      end
   end

   assign bus.b_jump        = w_b_jump;
   assign bus.pred_taken    = w_pred;
   assign bus.mispredict    = r_mispredict;
   assign bus.br_count      = r_br_count;
   assign bus.mispred_count = r_mispred_count;
endmodule

// File: tb/tb_branch_cmp_bht.sv
// Directed bench for branch_cmp_bht: compare ops, training, aliasing, stall,
// counter saturation (CNT_WIDTH=4) and mid-run reset.
module tb_branch_cmp_bht;
   localparam int WIDTH     = 32;
   localparam int IDX_BITS  = 4;
   localparam int CNT_WIDTH = 4;

   logic clk;
   logic reset;
   int   errors;
   int   checks;

   branch_cmp_bht_if #(.WIDTH(WIDTH), .CNT_WIDTH(CNT_WIDTH)) bif ();

   branch_cmp_bht #(.WIDTH(WIDTH), .IDX_BITS(IDX_BITS), .CNT_WIDTH(CNT_WIDTH)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bif)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic br, input logic stl, input logic [31:0] pc,
                        input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
      bif.is_branch = br;
      bif.stall     = stl;
      bif.pc        = pc;
      bif.cmp_op    = op;
      bif.cmp_a     = a;
      bif.cmp_b     = b;
      #1;
   endtask

   task automatic do_reset();
      drive(1'b0, 1'b0, 32'h0, 4'd0, 32'h0, 32'h0);
      reset = 1'b1;
      tick();
      tick();
      reset = 1'b0;
   endtask

   task automatic test_reset();
      do_reset();
      drive(1'b0, 1'b0, 32'h3000, 4'd0, 32'h0, 32'h0);
      checks++;
      if (bif.mispredict !== 1'b0) begin
         errors++; $display("FAIL reset_mispredict got=%b want=0", bif.mispredict);
      end
      checks++;
      if (bif.br_count !== 4'd0 || bif.mispred_count !== 4'd0) begin
         errors++; $display("FAIL reset_counts got=%0d/%0d want=0/0", bif.br_count, bif.mispred_count);
      end
      checks++;
      if (bif.pred_taken !== 1'b0) begin
         errors++; $display("FAIL reset_pred got=%b want=0", bif.pred_taken);
      end
   endtask

   task automatic test_compare_ops();
      logic [3:0] ops [10];
      logic       exp [10];
      ops = '{4'd7, 4'd8, 4'd9, 4'd10, 4'd3, 4'd4, 4'd1, 4'd2, 4'd5, 4'd6};
      exp = '{1'b1, 1'b0, 1'b0, 1'b1,  1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
      for (int i = 0; i < 10; i++) begin
         drive(1'b0, 1'b0, 32'h0, ops[i], 32'hFFFF_FFFF, 32'h1);
         checks++;
         if (bif.b_jump !== exp[i]) begin
            errors++; $display("FAIL cmp_neg1_vs_1 op=%0d got=%b want=%b", ops[i], bif.b_jump, exp[i]);
         end
      end
      drive(1'b0, 1'b0, 32'h0, 4'd1, 32'h8000_0000, 32'h8000_0000);
      checks++;
      if (bif.b_jump !== 1'b1) begin
         errors++; $display("FAIL cmp_eq_min got=%b want=1", bif.b_jump);
      end
      drive(1'b0, 1'b0, 32'h0, 4'd9, 32'h8000_0000, 32'h8000_0000);
      checks++;
      if (bif.b_jump !== 1'b1) begin
         errors++; $display("FAIL cmp_ge_min got=%b want=1", bif.b_jump);
      end
      drive(1'b0, 1'b0, 32'h0, 4'd4, 32'h0, 32'h0);
      checks++;
      if (bif.b_jump !== 1'b0) begin
         errors++; $display("FAIL cmp_gtz_zero got=%b want=0", bif.b_jump);
      end
      drive(1'b0, 1'b0, 32'h0, 4'd7, 32'h5, 32'hFFFF_FFFE);
      checks++;
      if (bif.b_jump !== 1'b0) begin
         errors++; $display("FAIL cmp_lt_pos_neg got=%b want=0", bif.b_jump);
      end
      drive(1'b0, 1'b0, 32'h0, 4'd12, 32'h0, 32'h0);
      checks++;
      if (bif.b_jump !== 1'b0) begin
         errors++; $display("FAIL cmp_op12 got=%b want=0", bif.b_jump);
      end
      drive(1'b0, 1'b0, 32'h0, 4'd0, 32'h7, 32'h7);
      checks++;
      if (bif.b_jump !== 1'b0) begin
         errors++; $display("FAIL cmp_none got=%b want=0", bif.b_jump);
      end
      // is_branch=0 throughout: nothing counted
      tick();
      checks++;
      if (bif.br_count !== 4'd0) begin
         errors++; $display("FAIL nonbranch_count got=%0d want=0", bif.br_count);
      end
   endtask

   task automatic test_training();
      logic exp_pred [4];
      logic exp_mis  [4];
      exp_pred = '{1'b0, 1'b1, 1'b1, 1'b1};
      exp_mis  = '{1'b1, 1'b0, 1'b0, 1'b0};
      for (int i = 0; i < 4; i++) begin
         drive(1'b1, 1'b0, 32'h3000, 4'd1, 32'h0, 32'h0);
         checks++;
         if (bif.pred_taken !== exp_pred[i]) begin
            errors++; $display("FAIL train_pred step=%0d got=%b want=%b", i, bif.pred_taken, exp_pred[i]);
         end
         tick();
         checks++;
         if (bif.mispredict !== exp_mis[i]) begin
            errors++; $display("FAIL train_mispredict step=%0d got=%b want=%b", i, bif.mispredict, exp_mis[i]);
         end
      end
      checks++;
      if (bif.br_count !== 4'd4 || bif.mispred_count !== 4'd1) begin
         errors++; $display("FAIL train_counts got=%0d/%0d want=4/1", bif.br_count, bif.mispred_count);
      end
   endtask

   task automatic test_aliasing();
      drive(1'b0, 1'b0, 32'h3040, 4'd0, 32'h0, 32'h0);
      checks++;
      if (bif.pred_taken !== 1'b1) begin
         errors++; $display("FAIL alias_read got=%b want=1", bif.pred_taken);
      end
      drive(1'b1, 1'b0, 32'h3040, 4'd0, 32'h0, 32'h0);
      tick();
      checks++;
      if (bif.mispredict !== 1'b1) begin
         errors++; $display("FAIL alias_mispredict got=%b want=1", bif.mispredict);
      end
      // shared entry now 2: still predicts taken
      drive(1'b1, 1'b0, 32'h3000, 4'd0, 32'h0, 32'h0);
      checks++;
      if (bif.pred_taken !== 1'b1) begin
         errors++; $display("FAIL alias_entry2 got=%b want=1", bif.pred_taken);
      end
      tick();
      // entry 1 now: saturation at 3 confirmed by two decrements reaching not-taken
      drive(1'b0, 1'b0, 32'h3000, 4'd0, 32'h0, 32'h0);
      checks++;
      if (bif.pred_taken !== 1'b0) begin
         errors++; $display("FAIL alias_entry1 got=%b want=0", bif.pred_taken);
      end
      checks++;
      if (bif.br_count !== 4'd6 || bif.mispred_count !== 4'd3) begin
         errors++; $display("FAIL alias_counts got=%0d/%0d want=6/3", bif.br_count, bif.mispred_count);
      end
   endtask

   task automatic test_stall();
      for (int i = 0; i < 5; i++) begin
         drive(1'b1, 1'b1, 32'h3000, 4'd1, 32'h0, 32'h0);
         checks++;
         if (bif.b_jump !== 1'b1 || bif.pred_taken !== 1'b0) begin
            errors++; $display("FAIL stall_outputs cyc=%0d got=%b%b want=10", i, bif.b_jump, bif.pred_taken);
         end
         tick();
         checks++;
         if (bif.mispredict !== 1'b0) begin
            errors++; $display("FAIL stall_mispredict cyc=%0d got=%b want=0", i, bif.mispredict);
         end
      end
      drive(1'b0, 1'b0, 32'h3000, 4'd0, 32'h0, 32'h0);
      checks++;
      if (bif.br_count !== 4'd6 || bif.mispred_count !== 4'd3 || bif.pred_taken !== 1'b0) begin
         errors++; $display("FAIL stall_state got=%0d/%0d pred=%b want=6/3 pred=0",
                            bif.br_count, bif.mispred_count, bif.pred_taken);
      end
   endtask

   task automatic test_back_to_back();
      drive(1'b1, 1'b0, 32'h3000, 4'd1, 32'h0, 32'h0);
      tick();
      checks++;
      if (bif.mispredict !== 1'b1) begin
         errors++; $display("FAIL b2b_first_mispredict got=%b want=1", bif.mispredict);
      end
      drive(1'b1, 1'b0, 32'h3000, 4'd1, 32'h0, 32'h0);
      checks++;
      if (bif.pred_taken !== 1'b1) begin
         errors++; $display("FAIL b2b_second_pred got=%b want=1", bif.pred_taken);
      end
      tick();
      checks++;
      if (bif.mispredict !== 1'b0) begin
         errors++; $display("FAIL b2b_second_mispredict got=%b want=0", bif.mispredict);
      end
   endtask

   task automatic test_saturation();
      logic want_pred;
      do_reset();
      for (int i = 0; i < 20; i++) begin
         want_pred = (i >= 16);
         drive(1'b1, 1'b0, 32'(i * 4), (i < 16) ? 4'd1 : 4'd0, 32'h0, 32'h0);
         checks++;
         if (bif.pred_taken !== want_pred) begin
            errors++; $display("FAIL sat_pred i=%0d got=%b want=%b", i, bif.pred_taken, want_pred);
         end
         tick();
      end
      checks++;
      if (bif.mispredict !== 1'b1) begin
         errors++; $display("FAIL sat_mispredict got=%b want=1", bif.mispredict);
      end
      checks++;
      if (bif.br_count !== 4'd15 || bif.mispred_count !== 4'd15) begin
         errors++; $display("FAIL sat_counts got=%0d/%0d want=15/15", bif.br_count, bif.mispred_count);
      end
   endtask

   task automatic test_reset_mid();
      drive(1'b1, 1'b0, 32'h3000, 4'd1, 32'h0, 32'h0);
      tick();
      tick();
      drive(1'b0, 1'b0, 32'h3000, 4'd0, 32'h0, 32'h0);
      checks++;
      if (bif.pred_taken !== 1'b1) begin
         errors++; $display("FAIL mid_trained got=%b want=1", bif.pred_taken);
      end
      drive(1'b1, 1'b0, 32'h3000, 4'd1, 32'h0, 32'h0);
      reset = 1'b1;
      tick();
      reset = 1'b0;
      checks++;
      if (bif.mispredict !== 1'b0 || bif.br_count !== 4'd0 || bif.mispred_count !== 4'd0) begin
         errors++; $display("FAIL mid_reset_state got=%b %0d/%0d want=0 0/0",
                            bif.mispredict, bif.br_count, bif.mispred_count);
      end
      drive(1'b0, 1'b0, 32'h0004, 4'd0, 32'h0, 32'h0);
      checks++;
      if (bif.pred_taken !== 1'b0) begin
         errors++; $display("FAIL mid_other_entry got=%b want=0", bif.pred_taken);
      end
      drive(1'b1, 1'b0, 32'h3000, 4'd1, 32'h0, 32'h0);
      checks++;
      if (bif.pred_taken !== 1'b0) begin
         errors++; $display("FAIL mid_first_pred got=%b want=0", bif.pred_taken);
      end
      tick();
      drive(1'b0, 1'b0, 32'h3000, 4'd0, 32'h0, 32'h0);
      checks++;
      if (bif.mispredict !== 1'b1 || bif.pred_taken !== 1'b1 || bif.br_count !== 4'd1) begin
         errors++; $display("FAIL mid_after_branch got=mis%b pred%b br%0d want=mis1 pred1 br1",
                            bif.mispredict, bif.pred_taken, bif.br_count);
      end
   endtask

   initial begin
      errors = 0;
      checks = 0;
      reset  = 1'b1;
      test_reset();
      test_compare_ops();
      test_training();
      test_aliasing();
      test_stall();
      test_back_to_back();
      test_saturation();
      test_reset_mid();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
